// File: rtl/status_frame_pkg.sv
// rtl/status_frame_pkg.sv - framing constants, status layout and FSM encoding shared with the command parser
package status_frame_pkg;

  localparam logic [7:0] SOF0 = 8'hEB;
  localparam logic [7:0] SOF1 = 8'h90;
  localparam logic [7:0] EOF0 = 8'h09;
  localparam logic [7:0] EOF1 = 8'hD7;

  localparam logic [7:0] SRC_ID_DEFAULT = 8'hBA;

  localparam int ST_SWITCH  = 0;
  localparam int ST_RESET_A = 1;
  localparam int ST_RESET_B = 2;
  localparam int ST_POWER_A = 3;
  localparam int ST_POWER_B = 4;
  localparam int ST_ERR     = 5;
  localparam int ST_EVENT   = 6;

  // Both CPUs powered, CPU A host, no reset pulses: the expected state after power-up.
  localparam logic [4:0] LAST_SENT_RESET = 5'h18;

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_LATCH = 6'b000010,
    S_SPACE = 6'b000100,
    S_PUSH  = 6'b001000,
    S_GAP   = 6'b010000,
    S_DONE  = 6'b100000
  } frame_state_e;

  function automatic logic [7:0] frame_chk(input logic [7:0] seq,
                                           input logic [7:0] src,
                                           input logic [7:0] status);
    return 8'h00 - seq - src - status;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                            input logic [7:0] seq,
                                            input logic [7:0] src,
                                            input logic [7:0] status,
                                            input logic [7:0] chk);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0: b = SOF0;
      3'd1: b = SOF1;
      3'd2: b = seq;
      3'd3: b = src;
      3'd4: b = status;
      3'd5: b = chk;
      3'd6: b = EOF0;
      3'd7: b = EOF1;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/status_frame_trigger.sv
// rtl/status_frame_trigger.sv - period timer, change detect, sticky error and pending coalescing
module status_frame_trigger
  import status_frame_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] status_raw,
  input  logic       error_in,
  input  logic       send_req,
  input  logic       start,
  input  logic       snap,
  output logic       pending,
  output logic [7:0] status
);

  localparam int unsigned TIMER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned TIMER_LAST_I = (PERIOD_CYCLES > 0) ? PERIOD_CYCLES - 1 : 0;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMER_LAST_I);
  localparam bit PERIODIC = (PERIOD_CYCLES != 0);

  logic [TIMER_W-1:0] timer;
  logic [4:0]         last_sent;
  logic               pending_q;
  logic               event_q;
  logic               err_sticky;
  logic               differs;
  logic               change;
  logic               timer_hit;
  logic               trig;

  assign differs   = (status_raw != last_sent);
  // The snapshot itself captures a difference seen in the LATCH cycle, so it must not requeue.
  assign change    = differs && !snap;
  assign timer_hit = PERIODIC && (timer == TIMER_LAST);
  assign trig      = send_req | timer_hit | change;
  assign pending   = pending_q | trig;

  always_comb begin
    status              = {3'b000, status_raw};
    status[ST_ERR]      = err_sticky;
    status[ST_EVENT]    = event_q | differs;
  end

  // Timer is cleared as the FSM leaves IDLE so it reads 0 during the snapshot cycle,
  // which spaces periodic snapshots exactly PERIOD_CYCLES apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer      <= '0;
      last_sent  <= LAST_SENT_RESET;
      pending_q  <= 1'b0;
      event_q    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (!PERIODIC || start || timer_hit) begin
        timer <= '0;
      end else begin
        timer <= timer + TIMER_W'(1);
      end
      pending_q  <= start ? 1'b0 : (pending_q | trig);
      event_q    <= snap ? 1'b0 : (event_q | change);
      err_sticky <= error_in | (err_sticky & ~snap);
      if (snap) begin
        last_sent <= status_raw;
      end
    end
  end

endmodule

// File: rtl/status_frame_tx.sv
// rtl/status_frame_tx.sv - builds 8-byte status frames and writes them into the UART TX FIFO
module status_frame_tx
  import status_frame_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = 1000000,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned COUNTER_W     = 5,
  parameter logic [7:0]  SRC_ID        = SRC_ID_DEFAULT,
  parameter int unsigned GAP           = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 switch,
  input  logic                 reset_a_signal,
  input  logic                 reset_b_signal,
  input  logic                 power_on_A,
  input  logic                 power_on_B,
  input  logic                 error_in,
  input  logic                 send_req,
  input  logic [COUNTER_W-1:0] tf_counter,
  output logic                 tf_push,
  output logic [7:0]           tdr,
  output logic                 busy,
  output logic                 frame_done,
  output logic [7:0]           seq
);

  localparam logic [COUNTER_W-1:0] ROOM_MAX = COUNTER_W'(FIFO_DEPTH - 8);
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  frame_state_e     state, state_n;
  logic [2:0]       idx, idx_n;
  logic [GAP_W-1:0] gap_cnt, gap_n;
  logic [7:0]       stat_r;
  logic [7:0]       chk_r;
  logic [7:0]       status;
  logic [4:0]       status_raw;
  logic             pending;
  logic             start;
  logic             snap;

  always_comb begin
    status_raw             = 5'b00000;
    status_raw[ST_SWITCH]  = switch;
    status_raw[ST_RESET_A] = reset_a_signal;
    status_raw[ST_RESET_B] = reset_b_signal;
    status_raw[ST_POWER_A] = power_on_A;
    status_raw[ST_POWER_B] = power_on_B;
  end

  assign start = (state == S_IDLE) && pending;
  assign snap  = (state == S_LATCH);

  status_frame_trigger #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_trigger (
    .clk        (clk),
    .rst_n      (rst_n),
    .status_raw (status_raw),
    .error_in   (error_in),
    .send_req   (send_req),
    .start      (start),
    .snap       (snap),
    .pending    (pending),
    .status     (status)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      gap_cnt <= gap_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    gap_n      = gap_cnt;
    tf_push    = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (pending) state_n = S_LATCH;
      end
      S_LATCH: state_n = S_SPACE;
      // Room for the whole frame is checked once; bytes then go out without further flow control.
      S_SPACE: begin
        if (tf_counter <= ROOM_MAX) begin
          state_n = S_PUSH;
          idx_n   = 3'd0;
        end
      end
      S_PUSH: begin
        tf_push = 1'b1;
        gap_n   = '0;
        if (GAP != 0) begin
          state_n = S_GAP;
        end else if (idx == 3'd7) begin
          state_n = S_DONE;
        end else begin
          idx_n = idx + 3'd1;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (idx == 3'd7) begin
            state_n = S_DONE;
          end else begin
            idx_n   = idx + 3'd1;
            state_n = S_PUSH;
          end
        end else begin
          gap_n = gap_cnt + GAP_W'(1);
        end
      end
      S_DONE: begin
        busy       = 1'b0;
        frame_done = 1'b1;
        state_n    = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq    <= 8'h00;
      stat_r <= 8'h00;
      chk_r  <= 8'h00;
    end else begin
      if (snap) begin
        stat_r <= status;
        chk_r  <= frame_chk(seq, SRC_ID, status);
      end
      if (state == S_DONE) begin
        seq <= seq + 8'd1;
      end
    end
  end

  assign tdr = tf_push ? frame_byte(idx, seq, SRC_ID, stat_r, chk_r) : 8'h00;

endmodule

// File: doc/status_frame_tx.md
Name: status_frame_tx

Overview:
Builds 8-byte status/telemetry frames for the switch board and pushes them into the UART TX FIFO toward the Control Center. It is the uplink counterpart of the command-frame parser and uses the same framing: EB 90 header, 4-byte body with zero-sum checksum, 09 D7 tail. Frames are sent periodically, on host request, or when any monitored status bit changes. It sits between the switch/reset/power control logic and the UART transmitter FIFO.

Parameters:
PERIOD_CYCLES, 1000000, clk cycles between periodic frames; 0 disables periodic sending
FIFO_DEPTH, 16, TX FIFO depth in bytes
COUNTER_W, 5, width of tf_counter (matches UART_FIFO_COUNTER_W)
SRC_ID, 8'hBA, source-ID byte placed in frame byte 3
GAP, 3, idle cycles after each tf_push pulse

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
switch  in  1  0 = CPU A is host, 1 = CPU B is host
reset_a_signal  in  1  CPU A reset pulse active
reset_b_signal  in  1  CPU B reset pulse active
power_on_A  in  1  CPU A power enable
power_on_B  in  1  CPU B power enable
error_in  in  1  one-cycle pulse: bad command frame received
send_req  in  1  one-cycle pulse: request an immediate status frame
tf_counter  in  COUNTER_W  current TX FIFO fill level
tf_push  out  1  one-cycle write strobe to the TX FIFO
tdr  out  8  byte written to the TX FIFO; valid while tf_push=1
busy  out  1  a frame is being latched or sent
frame_done  out  1  one-cycle pulse after the last byte of a frame
seq  out  8  sequence number of the next frame

Behaviour:
- Reset (async, rst_n=0): tf_push=0, tdr=00, busy=0, frame_done=0, seq=00, pending=0, err_sticky=0, timer=0, last_sent=8'h18, FSM=IDLE. Asserting reset mid-frame aborts the frame at once. No partial frame is resumed.
- Status byte: [0]switch [1]reset_a_signal [2]reset_b_signal [3]power_on_A [4]power_on_B [5]err_sticky [6]event [7]0.
- Frame: b0=EB b1=90 b2=seq b3=SRC_ID b4=status b5=chk b6=09 b7=D7. chk = (0 - (b2+b3+b4)) mod 256, so b2+b3+b4+b5 = 0 mod 256.
- Triggers, all OR-ed into a single pending flag:
  - send_req;
  - timer reaching PERIOD_CYCLES-1;
  - change: status[4:0] differs from last_sent[4:0]. Sets event=1 in the next snapshot.
- Triggers that arrive while busy coalesce: at most one further frame is queued.
- err_sticky is set by error_in and cleared at snapshot. If error_in arrives in the snapshot cycle, err_sticky stays set.
- Timer counts every cycle and restarts at 0 on each snapshot. It wraps at PERIOD_CYCLES-1.
- FSM:
  - IDLE: if pending -> LATCH.
  - LATCH: snapshot status into last_sent, compute chk, clear pending and event source, busy=1 -> SPACE.
  - SPACE: wait until tf_counter <= FIFO_DEPTH-8, then -> PUSH with idx=0.
  - PUSH: tf_push=1, tdr=byte[idx] -> GAP.
  - GAP: GAP cycles with tf_push=0. Then if idx=7 -> DONE, else idx+1 -> PUSH.
  - DONE: frame_done=1, seq <= seq+1 (wraps FF->00), busy=0 -> IDLE.
- Latency: trigger sampled in IDLE at edge t, snapshot at t+1, first tf_push at t+3 if the FIFO has room. One byte takes 1+GAP cycles, so 32 cycles per frame with default GAP.
- A full FIFO stalls only in SPACE. Room is checked once per frame, never per byte.
- Simultaneous send_req, timer expiry and change produce one frame, with event=1.

Decomposition:
- Shared package status_frame_pkg, common with the command parser:
  - SOF0=EB, SOF1=90, EOF0=09, EOF1=D7;
  - SRC_ID default;
  - status bit indices;
  - FSM state encodings (one-hot, 6 states).
- One natural sub-module, status_frame_trigger: period timer, change detect, err_sticky and pending coalescing. It outputs pending and event to the FSM.

Test Plan:
1. Release reset with switch=0, powers=1, then send_req pulse -> bytes EB 90 00 BA 18 2E 09 D7, pushes spaced 4 cycles apart, frame_done once, seq=01.
2. After test 1, set switch=1 -> frame EB 90 01 BA 59 EC 09 D7 (event bit set). With no further change, no further frame until the timer expires.
3. tf_counter=9 with FIFO_DEPTH=16, then send_req -> busy=1, no tf_push. Drop tf_counter to 8 -> first push on the next cycle.
4. PERIOD_CYCLES=100, idle inputs -> frames start 100 cycles apart with byte4=18 and seq incrementing. Starting from seq=FF, the next frame has seq=00.
5. error_in pulse mid-frame plus two send_req pulses while busy -> exactly one follow-up frame with byte4 bit5=1. The frame after that has bit5=0.
6. Assert rst_n=0 during byte 4 -> tf_push=0 immediately. After release, no bytes are pushed until a new trigger, which produces a full frame with seq=00.
